// File: rtl/epcq_flash_responder.sv
// Device-side stand-in for the EPCQ flash controller: read / page-program / sector-erase / 4-byte mode over a small byte array.
// Optional write protection of the low sectors is compiled in with `define EPCQ_RESP_WP_EN.
module epcq_flash_responder #(
   parameter int AW         = 12,
   parameter int SECT_AW    = 8,
   parameter int READ_LAT   = 3,
   parameter int READ_GAP   = 4,
   parameter int WRITE_CYC  = 300,
   parameter int ERASE_CYC  = 600,
   parameter int WP_SECTORS = 1
) (
   input  logic        clkin,
   input  logic        reset,
   input  logic        read,
   input  logic        rden,
   input  logic [31:0] addr,
   input  logic        write,
   input  logic [7:0]  datain,
   input  logic        shift_bytes,
   input  logic        sector_erase,
   input  logic        wren,
   input  logic        en4b_addr,
   output logic [7:0]  dataout,
   output logic        busy,
   output logic        data_valid,
   output logic        illegal_write,
   output logic        illegal_erase
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_PROG  = 3'd2;
   localparam logic [2:0] S_ERASE = 3'd3;
   localparam logic [2:0] S_EN4B  = 3'd4;

   localparam int TW = $clog2((ERASE_CYC > WRITE_CYC) ? ERASE_CYC : WRITE_CYC) + 1;
   localparam int IW = ((SECT_AW > 8) ? SECT_AW : 8) + 1;

   logic [7:0]    mem      [0:(2**AW)-1];
   logic [7:0]    page_buf [0:255];

   logic [2:0]    state;
   logic [TW-1:0] tmr;
   logic [IW-1:0] idx;
   logic [AW-1:0] op_addr;
   logic [8:0]    cnt;
   logic [7:0]    wptr;
   logic          mode4b;

   logic [31:0]   eff;
   logic          in_range, wp_hit, write_ok, erase_ok, shift_go;
   logic          mem_we;
   logic [AW-1:0] mem_wa, prog_wa, erase_wa;
   logic [7:0]    mem_wd, prog_wd;

   assign eff      = mode4b ? addr : {8'h00, addr[23:0]};
   assign in_range = (eff >> AW) == 32'd0;

`ifdef EPCQ_RESP_WP_EN
   assign wp_hit = in_range && (32'(eff[AW-1:SECT_AW]) < 32'(WP_SECTORS));
`else
   logic unused_wp;
   assign wp_hit    = 1'b0;
   assign unused_wp = (WP_SECTORS != 0);
`endif

   assign write_ok = wren && (cnt != 9'd0) && in_range && !wp_hit;
   assign erase_ok = wren && in_range && !wp_hit;
   assign shift_go = !reset && (state == S_IDLE) && shift_bytes && wren &&
                     !read && !write && !sector_erase && !en4b_addr;

   // Programming wraps inside the 256-byte page; flash can only clear bits, hence the AND.
   assign prog_wa  = {op_addr[AW-1:8], op_addr[7:0] + idx[7:0]};
   assign prog_wd  = mem[prog_wa] & page_buf[idx[7:0]];
   assign erase_wa = {op_addr[AW-1:SECT_AW], idx[SECT_AW-1:0]};

   always_comb begin
      mem_we = 1'b0;
      mem_wa = prog_wa;
      mem_wd = prog_wd;
      if (!reset && state == S_PROG && idx < IW'(cnt)) begin
         mem_we = 1'b1;
      end else if (!reset && state == S_ERASE && idx < IW'(2**SECT_AW)) begin
         mem_we = 1'b1;
         mem_wa = erase_wa;
         mem_wd = 8'hFF;
      end
   end

   // Array and page buffer survive reset, so a reset mid-operation leaves it partially applied.
   always_ff @(posedge clkin) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      if (shift_go) page_buf[wptr] <= datain;
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         data_valid    <= 1'b0;
         dataout       <= 8'h00;
         illegal_write <= 1'b0;
         illegal_erase <= 1'b0;
         cnt           <= 9'd0;
         wptr          <= 8'd0;
         mode4b        <= 1'b0;
         tmr           <= '0;
         idx           <= '0;
         op_addr       <= '0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               idx <= '0;
               if (read) begin
                  state   <= S_READ;
                  busy    <= 1'b1;
                  op_addr <= eff[AW-1:0];
                  tmr     <= TW'(READ_LAT - 1);
               end else if (write) begin
                  if (write_ok) begin
                     state         <= S_PROG;
                     busy          <= 1'b1;
                     op_addr       <= eff[AW-1:0];
                     tmr           <= TW'(WRITE_CYC - 1);
                     illegal_write <= 1'b0;
                  end else begin
                     illegal_write <= 1'b1;
                  end
               end else if (sector_erase) begin
                  if (erase_ok) begin
                     state         <= S_ERASE;
                     busy          <= 1'b1;
                     op_addr       <= eff[AW-1:0];
                     tmr           <= TW'(ERASE_CYC - 1);
                     illegal_erase <= 1'b0;
                  end else begin
                     illegal_erase <= 1'b1;
                  end
               end else if (en4b_addr) begin
                  if (wren) begin
                     state  <= S_EN4B;
                     busy   <= 1'b1;
                     mode4b <= 1'b1;
                     tmr    <= TW'(1);
                  end
               end else if (shift_go) begin
                  // wptr wraps so the last 256 shifted bytes are kept; cnt only saturates.
                  wptr          <= wptr + 8'd1;
                  illegal_write <= 1'b0;
                  if (cnt != 9'd256) cnt <= cnt + 9'd1;
               end
            end
            S_READ: begin
               if (tmr == '0) begin
                  if (rden) begin
                     data_valid <= 1'b1;
                     dataout    <= mem[op_addr];
                     op_addr    <= op_addr + AW'(1);
                     tmr        <= TW'(READ_GAP - 1);
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  tmr <= tmr - TW'(1);
               end
            end
            S_PROG, S_ERASE, S_EN4B: begin
               if (mem_we) idx <= idx + IW'(1);
               if (tmr == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  if (state == S_PROG) begin
                     cnt  <= 9'd0;
                     wptr <= 8'd0;
                  end
               end else begin
                  tmr <= tmr - TW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
